// File: rtl/riscv_core_pkg.sv
// Shared definitions for the multi-cycle RISC-V core: datapath width,
// fetch-stage FSM encoding and program-counter defaults.
package riscv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with a pending-redirect slot and the next-PC select
// (sequential increment, live redirect target or stashed redirect target).
module fetch_pc_reg
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_capture,
  input  logic            i_advance,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending;
  logic            r_pending_valid;
  logic [XLEN-1:0] w_pc_next;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_pc_next = r_pc;
    if (i_advance) begin
      // A redirect arriving with the ack beats a stashed one; both beat +STEP.
      if (i_redirect)           w_pc_next = i_target;
      else if (r_pending_valid) w_pc_next = r_pending;
      else                      w_pc_next = r_pc + PC_STEP;
    end else if (i_load) begin
      w_pc_next = i_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc            <= RESET_PC;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (i_advance || i_load) begin
        r_pending_valid <= 1'b0;
      end else if (i_capture) begin
        r_pending       <= i_target;
        r_pending_valid <= 1'b1;
      end
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, req/ack to instruction memory and a
// one-cycle irEnable pulse. Optional macro FETCH_MISALIGN_CHECK_EN adds a
// misaligned-fetch fault instead of silently aligning the address.
module fetch_unit
  import riscv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetchStart,
  input  logic            pcLoad,
  input  logic [XLEN-1:0] pcTarget,
  output logic            memReq,
  output logic [XLEN-1:0] memAddr,
  input  logic            memAck,
  input  logic [XLEN-1:0] memRdata,
  output logic [XLEN-1:0] instOut,
  output logic            irEnable,
  output logic [XLEN-1:0] instPc,
  output logic [XLEN-1:0] pcOut,
  output logic            busy,
  output logic            fetchFault
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fault;
  logic [XLEN-1:0] w_pc;
  logic            w_in_idle;
  logic            w_in_req;
  logic            w_in_done;
  logic            w_load;
  logic            w_capture;
  logic            w_advance;
  logic            w_start_ok;
  logic            w_start_bad;

  assign w_in_idle = (r_state == FETCH_IDLE);
  assign w_in_req  = (r_state == FETCH_REQ);
  assign w_in_done = (r_state == FETCH_DONE);

  assign w_load    = pcLoad && (w_in_idle || w_in_done);
  assign w_capture = pcLoad && w_in_req && !memAck;
  assign w_advance = w_in_req && memAck;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic [XLEN-1:0] w_start_addr;

  // A same-cycle redirect is the address the fetch would actually use.
  assign w_start_addr = pcLoad ? pcTarget : w_pc;
  assign w_start_bad  = w_in_idle && fetchStart && (w_start_addr[1:0] != 2'b00);
  assign w_start_ok   = w_in_idle && fetchStart && (w_start_addr[1:0] == 2'b00);
  assign memAddr      = w_pc;
`else
  assign w_start_bad  = 1'b0;
  assign w_start_ok   = w_in_idle && fetchStart;
  assign memAddr      = {w_pc[XLEN-1:2], 2'b00};
`endif

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_capture  (w_capture),
    .i_advance  (w_advance),
    .i_redirect (pcLoad),
    .i_target   (pcTarget),
    .o_pc       (w_pc)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FETCH_IDLE: if (w_start_ok) w_state_next = FETCH_REQ;
      FETCH_REQ:  if (memAck)     w_state_next = FETCH_DONE;
      FETCH_DONE:                 w_state_next = FETCH_IDLE;
      default:                    w_state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH_IDLE;
    else       r_state <= w_state_next;
  end

  // instOut only moves on an ack edge so the IR never latches a partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_fault <= w_start_bad;
      if (w_advance) begin
        r_inst    <= memRdata;
        r_inst_pc <= w_pc;
      end
    end
  end

  assign memReq     = w_in_req;
  assign irEnable   = w_in_done;
  assign busy       = !w_in_idle;
  assign instOut    = r_inst;
  assign instPc     = r_inst_pc;
  assign pcOut      = w_pc;
  assign fetchFault = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for the main fetch
// flows plus hand-written reset, wrap and misalignment sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetchStart = 1'b0;
  logic        pcLoad = 1'b0;
  logic [31:0] pcTarget = '0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;
  logic [31:0] instOut;
  logic        irEnable;
  logic [31:0] instPc;
  logic [31:0] pcOut;
  logic        busy;
  logic        fetchFault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .fetchStart (fetchStart),
    .pcLoad     (pcLoad),
    .pcTarget   (pcTarget),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memRdata   (memRdata),
    .instOut    (instOut),
    .irEnable   (irEnable),
    .instPc     (instPc),
    .pcOut      (pcOut),
    .busy       (busy),
    .fetchFault (fetchFault)
  );

  always #5 clk = ~clk;

  // One row = inputs driven during a cycle + outputs expected in that cycle.
  typedef struct {
    logic        fs;
    logic        pl;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        ire;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] pc;
    logic        busy;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fs, input logic pl, input logic [31:0] tgt,
                              input logic ack, input logic [31:0] rdata,
                              input logic req, input logic [31:0] addr, input logic ire,
                              input logic [31:0] inst, input logic [31:0] ipc,
                              input logic [31:0] pc, input logic bsy);
    vec_t v;
    v.fs = fs; v.pl = pl; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
    v.req = req; v.addr = addr; v.ire = ire; v.inst = inst; v.ipc = ipc;
    v.pc = pc; v.busy = bsy;
    return v;
  endfunction

  task automatic drive(input logic fs, input logic pl, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rdata);
    fetchStart = fs; pcLoad = pl; pcTarget = tgt; memAck = ack; memRdata = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fault_cnt;
    logic req_seen;

    //                fs pl tgt          ack rdata          req addr         ire inst           ipc          pc           busy
    vecs[0]  = mk(1, 0, 32'h0,       0, 32'h0,        0, 32'h0,   0, 32'h0,        32'h0,   32'h0,   0);
    vecs[1]  = mk(0, 0, 32'h0,       1, 32'h00500093, 1, 32'h0,   0, 32'h0,        32'h0,   32'h0,   1);
    vecs[2]  = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h4,   1, 32'h00500093, 32'h0,   32'h4,   1);
    vecs[3]  = mk(1, 0, 32'h0,       0, 32'h0,        0, 32'h4,   0, 32'h00500093, 32'h0,   32'h4,   0);
    vecs[4]  = mk(0, 0, 32'h0,       0, 32'h0,        1, 32'h4,   0, 32'h00500093, 32'h0,   32'h4,   1);
    vecs[5]  = mk(0, 0, 32'h0,       0, 32'h0,        1, 32'h4,   0, 32'h00500093, 32'h0,   32'h4,   1);
    vecs[6]  = mk(0, 0, 32'h0,       0, 32'h0,        1, 32'h4,   0, 32'h00500093, 32'h0,   32'h4,   1);
    vecs[7]  = mk(0, 0, 32'h0,       1, 32'h00a00113, 1, 32'h4,   0, 32'h00500093, 32'h0,   32'h4,   1);
    vecs[8]  = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h8,   1, 32'h00a00113, 32'h4,   32'h8,   1);
    vecs[9]  = mk(1, 0, 32'h0,       0, 32'h0,        0, 32'h8,   0, 32'h00a00113, 32'h4,   32'h8,   0);
    vecs[10] = mk(0, 1, 32'h100,     0, 32'h0,        1, 32'h8,   0, 32'h00a00113, 32'h4,   32'h8,   1);
    vecs[11] = mk(0, 0, 32'h0,       1, 32'h00000013, 1, 32'h8,   0, 32'h00a00113, 32'h4,   32'h8,   1);
    vecs[12] = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h100, 1, 32'h00000013, 32'h8,   32'h100, 1);
    vecs[13] = mk(1, 0, 32'h0,       0, 32'h0,        0, 32'h100, 0, 32'h00000013, 32'h8,   32'h100, 0);
    vecs[14] = mk(0, 0, 32'h0,       1, 32'h0000006f, 1, 32'h100, 0, 32'h00000013, 32'h8,   32'h100, 1);
    vecs[15] = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h104, 1, 32'h0000006f, 32'h100, 32'h104, 1);
    vecs[16] = mk(1, 1, 32'h40,      0, 32'h0,        0, 32'h104, 0, 32'h0000006f, 32'h100, 32'h104, 0);
    vecs[17] = mk(0, 0, 32'h0,       1, 32'h12345678, 1, 32'h40,  0, 32'h0000006f, 32'h100, 32'h40,  1);
    vecs[18] = mk(1, 1, 32'h200,     0, 32'h0,        0, 32'h44,  1, 32'h12345678, 32'h40,  32'h44,  1);
    vecs[19] = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h200, 0, 32'h12345678, 32'h40,  32'h200, 0);
    vecs[20] = mk(0, 0, 32'h0,       1, 32'hdeadbeef, 0, 32'h200, 0, 32'h12345678, 32'h40,  32'h200, 0);
    vecs[21] = mk(1, 0, 32'h0,       0, 32'h0,        0, 32'h200, 0, 32'h12345678, 32'h40,  32'h200, 0);
    vecs[22] = mk(0, 1, 32'h300,     0, 32'h0,        1, 32'h200, 0, 32'h12345678, 32'h40,  32'h200, 1);
    vecs[23] = mk(0, 1, 32'h400,     0, 32'h0,        1, 32'h200, 0, 32'h12345678, 32'h40,  32'h200, 1);
    vecs[24] = mk(0, 1, 32'h500,     1, 32'hcafef00d, 1, 32'h200, 0, 32'h12345678, 32'h40,  32'h200, 1);
    vecs[25] = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h500, 1, 32'hcafef00d, 32'h200, 32'h500, 1);
    vecs[26] = mk(0, 0, 32'h0,       0, 32'h0,        0, 32'h500, 0, 32'hcafef00d, 32'h200, 32'h500, 0);

    // Reset for two edges, released at a negedge.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      check($sformatf("v%0d memReq", i),     32'(memReq),     32'(vecs[i].req));
      check($sformatf("v%0d memAddr", i),    memAddr,         vecs[i].addr);
      check($sformatf("v%0d irEnable", i),   32'(irEnable),   32'(vecs[i].ire));
      check($sformatf("v%0d instOut", i),    instOut,         vecs[i].inst);
      check($sformatf("v%0d instPc", i),     instPc,          vecs[i].ipc);
      check($sformatf("v%0d pcOut", i),      pcOut,           vecs[i].pc);
      check($sformatf("v%0d busy", i),       32'(busy),       32'(vecs[i].busy));
      check($sformatf("v%0d fetchFault", i), 32'(fetchFault), 32'h0);
      drive(vecs[i].fs, vecs[i].pl, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
    end

    // Wrap: fetch at 0xFFFF_FFFC leaves pc at 0.
    @(negedge clk); drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    @(negedge clk);
    check("wrap pc_loaded", pcOut, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("wrap memReq", 32'(memReq), 32'h1);
    check("wrap memAddr", memAddr, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 1, 32'h00000073);
    @(negedge clk);
    check("wrap irEnable", 32'(irEnable), 32'h1);
    check("wrap instPc", instPc, 32'hFFFF_FFFC);
    check("wrap pcOut", pcOut, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);

    // Reset mid-REQ, then a stale ack after reset.
    @(negedge clk); drive(0, 1, 32'h80, 0, 32'h0);
    @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("rst req_before", 32'(memReq), 32'h1);
    check("rst addr_before", memAddr, 32'h80);
    drive(0, 0, 32'h0, 0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rst memReq", 32'(memReq), 32'h0);
    check("rst pcOut", pcOut, 32'h0);
    check("rst instOut", instOut, 32'h0);
    check("rst instPc", instPc, 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    reset = 1'b0;
    drive(0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst late_ack irEnable", 32'(irEnable), 32'h0);
    check("rst late_ack busy", 32'(busy), 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("rst late_ack irEnable2", 32'(irEnable), 32'h0);
    check("rst late_ack instOut", instOut, 32'h0);
    check("rst late_ack pcOut", pcOut, 32'h0);

    // Misaligned redirect followed by fetchStart.
    drive(0, 1, 32'h102, 0, 32'h0);
    @(negedge clk);
    check("mis pc_loaded", pcOut, 32'h102);
    drive(1, 0, 32'h0, 0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_cnt = 0;
    req_seen  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 32'h0);
      if (fetchFault) fault_cnt++;
      if (memReq) req_seen = 1'b1;
    end
    check("mis fault_pulses", 32'(fault_cnt), 32'h1);
    check("mis req_seen", 32'(req_seen), 32'h0);
    check("mis instOut", instOut, 32'h0);
    check("mis busy", 32'(busy), 32'h0);
    check("mis pcOut", pcOut, 32'h102);
`else
    fault_cnt = 0;
    req_seen  = 1'b0;
    @(negedge clk);
    check("mis memReq", 32'(memReq), 32'h1);
    check("mis memAddr", memAddr, 32'h100);
    check("mis fetchFault", 32'(fetchFault), 32'h0);
    drive(0, 0, 32'h0, 1, 32'h0000_1234);
    @(negedge clk);
    check("mis irEnable", 32'(irEnable), 32'h1);
    check("mis instOut", instOut, 32'h0000_1234);
    check("mis instPc", instPc, 32'h102);
    check("mis pcOut", pcOut, 32'h106);
    drive(0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("mis fetchFault_end", 32'(fetchFault), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
